// File: rtl/mips_multicycle_ctrl_if.sv
// Unified memory port handshake between the control FSM and memory.
// The controller requests; memory answers with mem_ready.
interface mips_multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output iord,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  iord,
        output mem_ready
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM: fetch/decode/exec/mem/wb sequencing,
// ALU ctrl code, PC/IR/regfile strobes, memory handshake with timeout trap.
module mips_multicycle_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            instr,
    input  logic                   cmp_eq,
    mips_multicycle_ctrl_if.master mem,
    output logic                   ir_we,
    output logic                   pc_we,
    output logic [1:0]             pc_src,
    output logic [11:0]            alu_ctrl,
    output logic                   alu_src_b,
    output logic                   reg_we,
    output logic                   reg_dst,
    output logic                   mem_to_reg,
    output logic [31:0]            retired,
    output logic                   trap,
    output logic [1:0]             trap_cause
);
    typedef enum logic [2:0] {
        S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [1:0] CAUSE_ILL = 2'b01;
    localparam logic [1:0] CAUSE_TMO = 2'b10;

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] retired_q, retired_d;
    logic [1:0]  trap_cause_q, trap_cause_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic        iord_q, iord_d;
    logic [1:0]  pc_src_q, pc_src_d;
    logic [11:0] alu_ctrl_q, alu_ctrl_d;
    logic        alu_src_b_q, alu_src_b_d;
    logic        reg_we_q, reg_we_d;
    logic        reg_dst_q, reg_dst_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic        trap_q, trap_d;

    logic [5:0]  op;
    logic [5:0]  fn;
    logic [11:0] alu_code;
    logic        is_addu, is_addiu, is_lw, is_sw, is_beq, is_j;
    logic        legal;
    logic        unused_instr;

    assign op           = instr[31:26];
    assign fn           = instr[5:0];
    assign unused_instr = ^instr[25:6];
    assign is_addu      = (op == 6'b000000) && (fn == 6'b100001);
    assign is_addiu     = (op == 6'b001001);
    assign is_lw        = (op == 6'b100011);
    assign is_sw        = (op == 6'b101011);
    assign is_beq       = (op == 6'b000100);
    assign is_j         = (op == 6'b000010);
    assign legal        = is_addu | is_addiu | is_lw | is_sw | is_beq | is_j;
    assign alu_code     = (op == 6'b000000) ? {op, fn} : {op, 6'b000000};

    // Next state, wait counter, retire count and the two mem_ready-dependent strobes
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        retired_d    = retired_q;
        trap_cause_d = trap_cause_q;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        unique case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
                wait_d  = '0;
            end
            S_FETCH: begin
                if (mem.mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d      = S_TRAP;
                    trap_cause_d = CAUSE_TMO;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d      = S_TRAP;
                    trap_cause_d = CAUSE_ILL;
                end
            end
            S_EXEC: begin
                if (is_addu || is_addiu) begin
                    state_d = S_WB;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end else if (is_beq || is_j) begin
                    pc_we     = is_j | cmp_eq;
                    retired_d = retired_q + 32'd1;
                    state_d   = S_FETCH;
                    wait_d    = '0;
                end else begin
                    state_d      = S_TRAP;
                    trap_cause_d = CAUSE_ILL;
                end
            end
            S_MEM: begin
                if (mem.mem_ready) begin
                    if (is_sw) begin
                        retired_d = retired_q + 32'd1;
                        state_d   = S_FETCH;
                        wait_d    = '0;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d      = S_TRAP;
                    trap_cause_d = CAUSE_TMO;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                retired_d = retired_q + 32'd1;
                state_d   = S_FETCH;
                wait_d    = '0;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    // Moore outputs of the state being entered, registered for glitch-free strobes
    always_comb begin
        mem_req_d    = (state_d == S_FETCH) || (state_d == S_MEM);
        mem_we_d     = (state_d == S_MEM) && is_sw;
        iord_d       = (state_d == S_MEM);
        pc_src_d     = 2'b00;
        alu_ctrl_d   = 12'd0;
        alu_src_b_d  = 1'b0;
        reg_we_d     = (state_d == S_WB);
        reg_dst_d    = (state_d == S_WB) && is_addu;
        mem_to_reg_d = (state_d == S_WB) && is_lw;
        trap_d       = (state_d == S_TRAP);
        if ((state_d == S_EXEC) || (state_d == S_MEM)) begin
            alu_ctrl_d  = alu_code;
            alu_src_b_d = is_addiu | is_lw | is_sw;
        end
        if (state_d == S_EXEC) begin
            if (is_beq) pc_src_d = 2'b01;
            if (is_j)   pc_src_d = 2'b10;
        end
    end

    // State and output registers; reset forces every output low at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_RESET;
            wait_q       <= '0;
            retired_q    <= '0;
            trap_cause_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            iord_q       <= 1'b0;
            pc_src_q     <= '0;
            alu_ctrl_q   <= '0;
            alu_src_b_q  <= 1'b0;
            reg_we_q     <= 1'b0;
            reg_dst_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            trap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            retired_q    <= retired_d;
            trap_cause_q <= trap_cause_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            iord_q       <= iord_d;
            pc_src_q     <= pc_src_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_src_b_q  <= alu_src_b_d;
            reg_we_q     <= reg_we_d;
            reg_dst_q    <= reg_dst_d;
            mem_to_reg_q <= mem_to_reg_d;
            trap_q       <= trap_d;
        end
    end

    assign mem.mem_req = mem_req_q;
    assign mem.mem_we  = mem_we_q;
    assign mem.iord    = iord_q;
    assign pc_src      = pc_src_q;
    assign alu_ctrl    = alu_ctrl_q;
    assign alu_src_b   = alu_src_b_q;
    assign reg_we      = reg_we_q;
    assign reg_dst     = reg_dst_q;
    assign mem_to_reg  = mem_to_reg_q;
    assign retired     = retired_q;
    assign trap        = trap_q;
    assign trap_cause  = trap_cause_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: an instruction-level model
// expands each instruction into expected per-cycle outputs.
module tb_mips_multicycle_ctrl;
    localparam int TIMEOUT = 64;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic        iord;
        logic        ir_we;
        logic        pc_we;
        logic [1:0]  pc_src;
        logic [11:0] alu_ctrl;
        logic        alu_src_b;
        logic        reg_we;
        logic        reg_dst;
        logic        mem_to_reg;
        logic [31:0] retired;
        logic        trap;
        logic [1:0]  trap_cause;
    } outv_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        cmp_eq = 1'b0;
    logic        ir_we, pc_we, alu_src_b, reg_we, reg_dst, mem_to_reg, trap;
    logic [1:0]  pc_src, trap_cause;
    logic [11:0] alu_ctrl;
    logic [31:0] retired;

    mips_multicycle_ctrl_if mif ();

    mips_multicycle_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .cmp_eq     (cmp_eq),
        .mem        (mif),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .alu_ctrl   (alu_ctrl),
        .alu_src_b  (alu_src_b),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .retired    (retired),
        .trap       (trap),
        .trap_cause (trap_cause)
    );

    always #5 clk = ~clk;

    outv_t       exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] ret_m = '0;
    logic        trap_m = 1'b0;
    logic [1:0]  cause_m = '0;
    logic [31:0] cur_ir = '0;

    // Monitor: every cycle with an expected record is compared in full
    always @(negedge clk) begin
        outv_t e, a;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.mem_req    = mif.mem_req;
            a.mem_we     = mif.mem_we;
            a.iord       = mif.iord;
            a.ir_we      = ir_we;
            a.pc_we      = pc_we;
            a.pc_src     = pc_src;
            a.alu_ctrl   = alu_ctrl;
            a.alu_src_b  = alu_src_b;
            a.reg_we     = reg_we;
            a.reg_dst    = reg_dst;
            a.mem_to_reg = mem_to_reg;
            a.retired    = retired;
            a.trap       = trap;
            a.trap_cause = trap_cause;
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs cyc %0d: got %h exp %h", cyc, a, e);
            end
        end
    end

    function automatic logic rbit();
        int unsigned r;
        r = $urandom_range(0, 1);
        return r[0];
    endfunction

    function automatic outv_t idle();
        outv_t e;
        e            = '0;
        e.retired    = ret_m;
        e.trap       = trap_m;
        e.trap_cause = cause_m;
        return e;
    endfunction

    function automatic bit legal(input logic [31:0] ins);
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        case (op)
            6'd0:                        return fn == 6'b100001;
            6'd9, 6'd35, 6'd43, 6'd4, 6'd2: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

    task automatic step(input outv_t e, input logic mr, input logic ce, input logic r);
        @(posedge clk);
        #1;
        rst           = r;
        mif.mem_ready = mr;
        cmp_eq        = ce;
        instr         = cur_ir;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        outv_t z;
        ret_m   = '0;
        trap_m  = 1'b0;
        cause_m = '0;
        z       = idle();
        step(z, rbit(), 1'b0, 1'b1);
        step(z, rbit(), 1'b0, 1'b1);
        step(z, rbit(), 1'b0, 1'b0);
    endtask

    task automatic trap_cycles(input int n);
        for (int i = 0; i < n; i++) step(idle(), rbit(), rbit(), 1'b0);
    endtask

    task automatic mem_wait(input outv_t e, input int w, input bit is_fetch,
                            output bit tmo);
        outv_t d;
        int    n;
        n   = (w >= TIMEOUT) ? TIMEOUT : w;
        tmo = 1'b0;
        for (int i = 0; i < n; i++) step(e, 1'b0, rbit(), 1'b0);
        if (w >= TIMEOUT) begin
            tmo     = 1'b1;
            trap_m  = 1'b1;
            cause_m = 2'b10;
        end else begin
            d = e;
            if (is_fetch) begin
                d.ir_we = 1'b1;
                d.pc_we = 1'b1;
            end
            step(d, 1'b1, rbit(), 1'b0);
        end
    endtask

    task automatic run_instr(input logic [31:0] ins, input int wf, input int wm,
                             input logic ce, input int abort_at);
        outv_t       e;
        bit          tmo;
        logic [5:0]  op, fn;
        logic [11:0] code;
        bit          ad, ai, l, s, b, j;
        e         = idle();
        e.mem_req = 1'b1;
        mem_wait(e, wf, 1'b1, tmo);
        if (tmo) return;
        cur_ir = ins;
        step(idle(), rbit(), rbit(), 1'b0);
        if (!legal(ins)) begin
            trap_m  = 1'b1;
            cause_m = 2'b01;
            return;
        end
        op   = ins[31:26];
        fn   = ins[5:0];
        code = (op == 6'd0) ? {op, fn} : {op, 6'd0};
        ad   = (op == 6'd0);
        ai   = (op == 6'd9);
        l    = (op == 6'd35);
        s    = (op == 6'd43);
        b    = (op == 6'd4);
        j    = (op == 6'd2);
        e           = idle();
        e.alu_ctrl  = code;
        e.alu_src_b = ai | l | s;
        if (b) begin
            e.pc_src = 2'b01;
            e.pc_we  = ce;
        end
        if (j) begin
            e.pc_src = 2'b10;
            e.pc_we  = 1'b1;
        end
        step(e, rbit(), ce, 1'b0);
        if (b || j) begin
            ret_m++;
            return;
        end
        if (l || s) begin
            e           = idle();
            e.mem_req   = 1'b1;
            e.iord      = 1'b1;
            e.mem_we    = s;
            e.alu_ctrl  = code;
            e.alu_src_b = 1'b1;
            if (abort_at >= 0) begin
                for (int i = 0; i < abort_at; i++) step(e, 1'b0, rbit(), 1'b0);
                return;
            end
            mem_wait(e, wm, 1'b0, tmo);
            if (tmo) return;
            if (s) begin
                ret_m++;
                return;
            end
        end
        e            = idle();
        e.reg_we     = 1'b1;
        e.reg_dst    = ad;
        e.mem_to_reg = l;
        step(e, rbit(), rbit(), 1'b0);
        ret_m++;
    endtask

    function automatic logic [31:0] gen(input int k);
        logic [31:0] r;
        logic [5:0]  x;
        r = $urandom;
        x = r[31:26];
        case (k)
            0:       return {6'd0, r[25:6], 6'b100001};
            1:       return {6'd9, r[25:0]};
            2:       return {6'd35, r[25:0]};
            3:       return {6'd43, r[25:0]};
            4:       return {6'd4, r[25:0]};
            5:       return {6'd2, r[25:0]};
            6: begin
                if (legal({x, r[25:0]}) || x == 6'd0) x = 6'h3F;
                return {x, r[25:0]};
            end
            default: begin
                if (r[5:0] == 6'b100001) return {6'd0, r[25:6], 6'b100000};
                return {6'd0, r[25:0]};
            end
        endcase
    endfunction

    function automatic int rwait();
        int r;
        r = $urandom_range(0, 59);
        if (r == 0) return TIMEOUT - 1;
        if (r == 1) return TIMEOUT;
        return r % 5;
    endfunction

    initial begin
        mif.mem_ready = 1'b0;
        do_reset();
        run_instr(32'h24220005, 0, 0, 1'b0, -1);
        run_instr({6'd35, 26'h0431_0004}, 3, 3, 1'b0, -1);
        run_instr({6'd43, 26'h0431_0008}, 3, 3, 1'b0, -1);
        run_instr({6'd4, 26'h0022_0003}, 0, 0, 1'b0, -1);
        run_instr({6'd4, 26'h0022_0003}, 0, 0, 1'b1, -1);
        run_instr({6'd2, 26'h000_0040}, 1, 0, 1'b0, -1);
        run_instr({6'd0, 20'h22181, 6'b100001}, TIMEOUT - 1, 0, 1'b0, -1);
        run_instr({6'd35, 26'h0431_0004}, 0, 0, 1'b0, 2);
        do_reset();
        run_instr({6'h3F, 26'h123_4567}, 0, 0, 1'b0, -1);
        trap_cycles(6);
        do_reset();
        run_instr({6'd9, 26'h0}, TIMEOUT, 0, 1'b0, -1);
        trap_cycles(5);
        do_reset();
        for (int i = 0; i < 150; i++) begin
            int k;
            k = $urandom_range(0, 19);
            k = (k >= 18) ? k - 12 : k / 3;
            run_instr(gen(k), rwait(), rwait(), rbit(), -1);
            if (trap_m) begin
                trap_cycles(3);
                do_reset();
            end
        end
        @(negedge clk);
        #1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d left exp 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
